// File: rtl/pattern_checker.sv
// ============================================================================
//  Module      : pattern_checker
//  Description : On-chip pattern replay checker. Accepts one test pattern at a
//                time (stimulus, expected response, compare mask), drives the
//                stimulus to a combinational DUT, waits SETTLE clock edges,
//                then compares the sampled DUT response under the mask and
//                accumulates saturating pass/fail counters and status.
//  Option      : define PATTERN_CHECKER_MISR_EN to add a 16-bit MISR
//                signature (misr_sig) of the masked DUT responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_checker #(
    parameter int NINPUTS  = 5,
    parameter int NOUTPUTS = 2,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                pat_valid,
    output logic                pat_ready,
    input  logic [NINPUTS-1:0]  pat_pi,
    input  logic [NOUTPUTS-1:0] pat_xpct,
    input  logic [NOUTPUTS-1:0] pat_mask,
    input  logic                pat_last,
    output logic [NINPUTS-1:0]  dut_pi,
    input  logic [NOUTPUTS-1:0] dut_po,
    output logic                fail_pulse,
    output logic [NOUTPUTS-1:0] fail_bits,
    output logic [CNT_W-1:0]    pat_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic                first_fail_vld,
    output logic [CNT_W-1:0]    first_fail_idx,
`ifdef PATTERN_CHECKER_MISR_EN
    output logic [15:0]         misr_sig,
`endif
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE);

    state_t                state;
    logic [7:0]            settle_cnt;
    logic [NOUTPUTS-1:0]   xpct_q;
    logic [NOUTPUTS-1:0]   mask_q;
    logic                  last_q;

    logic [NOUTPUTS-1:0]   fail_bits_next;
    logic                  compare_fire;
    logic                  accept;

    // Masked miscompare of the live DUT response; masked-off bits never fail.
    assign fail_bits_next = (dut_po ^ xpct_q) & mask_q;

    // Compare happens on the last settle edge; clr overrides it.
    assign compare_fire = (state == S_WAIT) && (settle_cnt == 8'd1) && !clr;
    assign accept       = (state == S_IDLE) && pat_valid && !clr;

    // Status decoded directly from the state register; ready is held low in reset.
    assign pat_ready = (state == S_IDLE) && rst_n;
    assign busy      = (state == S_WAIT);
    assign done      = (state == S_DONE);

    // Main control FSM with compare, counters and first-fail capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            settle_cnt     <= 8'd0;
            xpct_q         <= '0;
            mask_q         <= '0;
            last_q         <= 1'b0;
            dut_pi         <= '0;
            fail_pulse     <= 1'b0;
            fail_bits      <= '0;
            pat_cnt        <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (clr) begin
            state          <= S_IDLE;
            settle_cnt     <= 8'd0;
            last_q         <= 1'b0;
            dut_pi         <= '0;
            fail_pulse     <= 1'b0;
            fail_bits      <= '0;
            pat_cnt        <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            fail_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dut_pi     <= pat_pi;
                        xpct_q     <= pat_xpct;
                        mask_q     <= pat_mask;
                        last_q     <= pat_last;
                        settle_cnt <= SETTLE_INIT;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (compare_fire) begin
                        fail_bits  <= fail_bits_next;
                        fail_pulse <= |fail_bits_next;
                        if (pat_cnt != CNT_MAX) begin
                            pat_cnt <= pat_cnt + 1'b1;
                        end
                        if (|fail_bits_next) begin
                            if (fail_cnt != CNT_MAX) begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_idx <= pat_cnt;
                            end
                        end
                        state <= last_q ? S_DONE : S_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PATTERN_CHECKER_MISR_EN
    logic [15:0] misr_next;

    // CRC-CCITT style shift with the masked response folded into the low bits.
    assign misr_next = {misr_sig[14:0], 1'b0}
                     ^ (misr_sig[15] ? 16'h1021 : 16'h0000)
                     ^ 16'(dut_po & mask_q);

    // Signature register advances once per compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_sig <= 16'h0000;
        end else if (clr) begin
            misr_sig <= 16'h0000;
        end else if (compare_fire) begin
            misr_sig <= misr_next;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_checker.sv
// ============================================================================
//  Module      : tb_pattern_checker
//  Description : Scoreboard bench for pattern_checker. A driver issues
//                directed and random patterns and pushes the expected
//                compare outcome from a reference model; a monitor pops and
//                checks whenever the checker finishes a compare.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pattern_checker;

    localparam int NI = 5;
    localparam int NO = 2;
    localparam int ST = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [NI-1:0] pat_pi = '0;
    logic [NO-1:0] pat_xpct = '0;
    logic [NO-1:0] pat_mask = '0;
    logic          pat_last = 1'b0;
    logic [NI-1:0] dut_pi;
    logic [NO-1:0] dut_po;
    logic          fail_pulse;
    logic [NO-1:0] fail_bits;
    logic [CW-1:0] pat_cnt;
    logic [CW-1:0] fail_cnt;
    logic          first_fail_vld;
    logic [CW-1:0] first_fail_idx;
    logic          busy;
    logic          done;
`ifdef PATTERN_CHECKER_MISR_EN
    logic [15:0]   misr_sig;
`endif

    pattern_checker #(
        .NINPUTS (NI),
        .NOUTPUTS(NO),
        .SETTLE  (ST),
        .CNT_W   (CW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .pat_valid     (pat_valid),
        .pat_ready     (pat_ready),
        .pat_pi        (pat_pi),
        .pat_xpct      (pat_xpct),
        .pat_mask      (pat_mask),
        .pat_last      (pat_last),
        .dut_pi        (dut_pi),
        .dut_po        (dut_po),
        .fail_pulse    (fail_pulse),
        .fail_bits     (fail_bits),
        .pat_cnt       (pat_cnt),
        .fail_cnt      (fail_cnt),
        .first_fail_vld(first_fail_vld),
        .first_fail_idx(first_fail_idx),
`ifdef PATTERN_CHECKER_MISR_EN
        .misr_sig      (misr_sig),
`endif
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational device under test: either a small logic function or a forced constant.
    logic          po_const_en = 1'b1;
    logic [NO-1:0] po_const = '0;

    function automatic logic [NO-1:0] dut_fn(input logic [NI-1:0] pi);
        return {pi[4] ^ pi[2], pi[0] & pi[3]};
    endfunction

    assign dut_po = po_const_en ? po_const : dut_fn(dut_pi);

    // Scoreboard
    typedef struct {
        logic [NI-1:0] pi;
        logic [NO-1:0] fb;
        logic          pulse;
        logic [CW-1:0] pc;
        logic [CW-1:0] fc;
        logic          ffv;
        logic [CW-1:0] ffi;
        logic          dn;
        logic [15:0]   misr;
        int            hs;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    bit skip_fall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_pat, m_fail, m_ffi;
    bit          m_ffv, m_done;
    logic [15:0] m_misr;

    task automatic m_reset();
        m_pat = 0; m_fail = 0; m_ffi = 0; m_ffv = 0; m_done = 0; m_misr = 16'h0;
    endtask

    task automatic send_pat(input logic [NI-1:0] pi, input logic [NO-1:0] x,
                            input logic [NO-1:0] m, input logic last);
        int n;
        logic [NO-1:0] po;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        while (!pat_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pat_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        po = po_const_en ? po_const : dut_fn(pi);
        e.pi = pi;
        e.fb = (po ^ x) & m;
        e.pulse = |e.fb;
        if (e.pulse && !m_ffv) begin
            m_ffv = 1;
            m_ffi = m_pat;
        end
        if (m_pat < CMAX) m_pat++;
        if (e.pulse && m_fail < CMAX) m_fail++;
        m_done = last;
        m_misr = {m_misr[14:0], 1'b0} ^ (m_misr[15] ? 16'h1021 : 16'h0) ^ {14'd0, po & m};
        e.pc = CW'(m_pat);
        e.fc = CW'(m_fail);
        e.ffv = m_ffv;
        e.ffi = CW'(m_ffi);
        e.dn = last;
        e.misr = m_misr;
        e.hs = cyc + 1;
        sb.push_back(e);
        pat_pi = pi; pat_xpct = x; pat_mask = m; pat_last = last; pat_valid = 1'b1;
        @(posedge clk); #1;
        pat_valid = 1'b0; pat_last = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk); #2;
        skip_fall = busy;
        clr = 1'b1;
        sb.delete();
        m_reset();
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy || sb.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pat_cnt"}, pat_cnt, 0);
        chk({tag, "_fail_cnt"}, fail_cnt, 0);
        chk({tag, "_ffv"}, first_fail_vld, 0);
        chk({tag, "_ffi"}, first_fail_idx, 0);
        chk({tag, "_fail_bits"}, fail_bits, 0);
        chk({tag, "_fail_pulse"}, fail_pulse, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dut_pi"}, dut_pi, 0);
`ifdef PATTERN_CHECKER_MISR_EN
        chk({tag, "_misr"}, misr_sig, 0);
`endif
    endtask

    // Monitor: checks every completed compare against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   busy_prev;
        int   wcnt;
        busy_prev = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 1'b0;
                skip_fall = 1'b0;
                wcnt = 0;
            end else begin
                if (busy && !busy_prev && sb.size() > 0)
                    chk("dut_pi", dut_pi, sb[0].pi);
                if (busy_prev && !busy) begin
                    if (skip_fall) begin
                        skip_fall = 1'b0;
                    end else if (sb.size() == 0) begin
                        chk("unexpected_compare", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        wcnt = 0;
                        chk("latency", cyc - e.hs, ST);
                        chk("fail_bits", fail_bits, e.fb);
                        chk("fail_pulse", fail_pulse, e.pulse);
                        chk("pat_cnt", pat_cnt, e.pc);
                        chk("fail_cnt", fail_cnt, e.fc);
                        chk("first_fail_vld", first_fail_vld, e.ffv);
                        chk("first_fail_idx", first_fail_idx, e.ffi);
                        chk("done", done, e.dn);
                        chk("pat_ready", pat_ready, !e.dn);
`ifdef PATTERN_CHECKER_MISR_EN
                        chk("misr_sig", misr_sig, e.misr);
`endif
                    end
                end else if (fail_pulse) begin
                    chk("pulse_extra", fail_pulse, 0);
                end
                if (sb.size() > 0) begin
                    wcnt++;
                    if (wcnt > ST + 6) begin
                        chk("compare_timeout", 32'd0, 32'd1);
                        sb.delete();
                        wcnt = 0;
                    end
                end else begin
                    wcnt = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // Driver: directed scenarios followed by randomized patterns.
    initial begin : driver
        int r;
        logic [CW-1:0] snap;
        m_reset();
        #1;
        chk("rst_pat_ready", pat_ready, 0);
        chk_zero("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", pat_ready, 1);

        // Single passing pattern
        po_const_en = 1'b1; po_const = 2'b10;
        send_pat(5'b11101, 2'b10, 2'b11, 1'b0);
        wait_idle();

        // Three patterns, second miscompares on bit 0, last ends the set
        do_clr();
        po_const = 2'b00;
        send_pat(5'b00001, 2'b00, 2'b11, 1'b0);
        send_pat(5'b00010, 2'b01, 2'b11, 1'b0);
        send_pat(5'b00011, 2'b00, 2'b11, 1'b1);
        wait_idle();
        chk("set_ffi", first_fail_idx, 1);

        // Masked-off difference passes
        do_clr();
        chk_zero("clr");
        chk("clr_ready", pat_ready, 1);
        po_const = 2'b01;
        send_pat(5'b01000, 2'b00, 2'b10, 1'b0);
        wait_idle();

        // Abort in WAIT, then a pattern offered while DONE
        send_pat(5'b00111, 2'b11, 2'b11, 1'b0);
        @(posedge clk);
        do_clr();
        repeat (ST + 2) @(posedge clk);
        #1;
        chk("abort_pat_cnt", pat_cnt, 0);
        chk("abort_fail_cnt", fail_cnt, 0);
        send_pat(5'b10101, 2'b01, 2'b11, 1'b1);
        wait_idle();
        snap = pat_cnt;
        pat_pi = 5'b11111; pat_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_ready", pat_ready, 0);
            chk("done_busy", busy, 0);
        end
        pat_valid = 1'b0;
        chk("done_no_count", pat_cnt, snap);
        do_clr();
        chk_zero("clr2");
        chk("clr2_ready", pat_ready, 1);

`ifdef PATTERN_CHECKER_MISR_EN
        // Signature of masked responses 10 then 01
        po_const = 2'b10;
        send_pat(5'b00000, 2'b00, 2'b11, 1'b0);
        wait_idle();
        chk("misr_1", misr_sig, 16'h0002);
        po_const = 2'b01;
        send_pat(5'b00000, 2'b00, 2'b11, 1'b0);
        wait_idle();
        chk("misr_2", misr_sig, 16'h0005);
        do_clr();
`endif

        // Counter saturation with 2^CW+2 failing patterns
        po_const = 2'b00;
        for (int i = 0; i < CMAX + 3; i++) send_pat(NI'(i), 2'b11, 2'b11, 1'b0);
        wait_idle();
        chk("sat_pat_cnt", pat_cnt, 4'hF);
        chk("sat_fail_cnt", fail_cnt, 4'hF);
        chk("sat_ffi", first_fail_idx, 0);

        // Randomized patterns against the logic-function DUT
        do_clr();
        po_const_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (m_done) do_clr();
            r = $urandom_range(0, 11);
            if (r == 0) begin
                send_pat(NI'($urandom), NO'($urandom), NO'($urandom), 1'b0);
                repeat ($urandom_range(0, ST - 2)) @(posedge clk);
                do_clr();
            end else begin
                send_pat(NI'($urandom), NO'($urandom), NO'($urandom), r == 1);
            end
        end
        wait_idle();

        // Asynchronous reset in the middle of WAIT
        if (m_done) do_clr();
        send_pat(5'b10110, 2'b11, 2'b11, 1'b0);
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        m_reset();
        #1;
        chk("arst_ready", pat_ready, 0);
        chk_zero("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ST + 2) @(posedge clk);
        #1;
        chk("arst_after_cnt", pat_cnt, 0);
        chk("arst_after_ready", pat_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
